// File: rtl/serial_addsub_pkg.sv
// ============================================================================
// Module      : serial_addsub_pkg
// Description : Shared state encoding and operation mode constants.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

package serial_addsub_pkg;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      RUN  = 2'd1,
      DONE = 2'd2
   } state_t;

   localparam logic MODE_ADD = 1'b0;
   localparam logic MODE_SUB = 1'b1;

endpackage

`default_nettype wire

// File: rtl/serial_addsub_digit_adder.sv
// ============================================================================
// Module      : digit_adder
// Description : Combinational DIGIT-bit ripple adder. It also exposes the
//               carry into the top bit so the caller can derive overflow.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module digit_adder #(
   parameter int DIGIT = 4
) (
   input  logic [DIGIT-1:0] a,
   input  logic [DIGIT-1:0] b,
   input  logic             cin,
   output logic [DIGIT-1:0] s,
   output logic             cout,
   output logic             c_msb
);

   logic [DIGIT:0] w_c;

   assign w_c[0] = cin;

   generate
      for (genvar i = 0; i < DIGIT; i++) begin : g_ripple
         assign s[i]     = a[i] ^ b[i] ^ w_c[i];
         assign w_c[i+1] = (a[i] & b[i]) | (w_c[i] & (a[i] ^ b[i]));
      end
   endgenerate

   assign cout  = w_c[DIGIT];
   assign c_msb = w_c[DIGIT-1];

endmodule

`default_nettype wire

// File: rtl/serial_addsub.sv
// ============================================================================
// Module      : serial_addsub
// Description : Digit-serial adder/subtractor, LSB digit first, with
//               valid/ready handshakes on the operand and result sides.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module serial_addsub
   import serial_addsub_pkg::*;
#(
   parameter int WIDTH = 16,
   parameter int DIGIT = 4
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             in_valid,
   output logic             in_ready,
   input  logic [WIDTH-1:0] A,
   input  logic [WIDTH-1:0] B,
   input  logic             Cin,
   input  logic             Sub,
   output logic             out_valid,
   input  logic             out_ready,
   output logic [WIDTH-1:0] Sum,
   output logic             Cout,
   output logic             Ovf
);

   localparam int NDIG = WIDTH / DIGIT;
   localparam int CW   = (NDIG > 1) ? $clog2(NDIG) : 1;

   generate
      if ((DIGIT < 1) || ((WIDTH % DIGIT) != 0)) begin : g_param_check
         $error("serial_addsub: WIDTH must be a positive multiple of DIGIT");
      end
   endgenerate

   state_t           r_state;
   state_t           w_state_nxt;
   logic             w_accept;
   logic             w_last;

   logic [WIDTH-1:0] r_a;
   logic [WIDTH-1:0] r_b;
   logic [WIDTH-1:0] r_acc;
   logic             r_c;
   logic [CW-1:0]    r_cnt;

   logic [DIGIT-1:0] w_ds;
   logic             w_dcout;
   logic             w_dcmsb;
   logic [WIDTH-1:0] w_acc_nxt;

   digit_adder #(
      .DIGIT (DIGIT)
   ) u_digit_adder (
      .a     (r_a[DIGIT-1:0]),
      .b     (r_b[DIGIT-1:0]),
      .cin   (r_c),
      .s     (w_ds),
      .cout  (w_dcout),
      .c_msb (w_dcmsb)
   );

   // New digit enters at the top so the LSB digit ends up at bit 0 after NDIG shifts
   assign w_acc_nxt = (WIDTH'(w_ds) << (WIDTH - DIGIT)) | (r_acc >> DIGIT);

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         r_state <= IDLE;
      end else begin
         r_state <= w_state_nxt;
      end
   end

   always_comb begin
      w_state_nxt = r_state;
      in_ready    = 1'b0;
      out_valid   = 1'b0;
      w_accept    = 1'b0;
      w_last      = 1'b0;
      case (r_state)
         IDLE: begin
            in_ready = 1'b1;
            if (in_valid) begin
               w_accept    = 1'b1;
               w_state_nxt = RUN;
            end
         end
         RUN: begin
            w_last = (r_cnt == CW'(NDIG - 1));
            if (w_last) begin
               w_state_nxt = DONE;
            end
         end
         DONE: begin
            out_valid = 1'b1;
            if (out_ready) begin
               w_state_nxt = IDLE;
            end
         end
         default: begin
            w_state_nxt = IDLE;
         end
      endcase
   end

   // Results are published only on the final digit, so Sum/Cout/Ovf never expose partial work
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         r_a   <= '0;
         r_b   <= '0;
         r_acc <= '0;
         r_c   <= 1'b0;
         r_cnt <= '0;
         Sum   <= '0;
         Cout  <= 1'b0;
         Ovf   <= 1'b0;
      end else if (w_accept) begin
         r_a   <= A;
         r_b   <= (Sub == MODE_SUB) ? ~B : B;
         r_c   <= (Sub == MODE_SUB) ? ~Cin : Cin;
         r_cnt <= '0;
      end else if (r_state == RUN) begin
         r_a   <= r_a >> DIGIT;
         r_b   <= r_b >> DIGIT;
         r_c   <= w_dcout;
         r_acc <= w_acc_nxt;
         r_cnt <= r_cnt + CW'(1);
         if (w_last) begin
            Sum  <= w_acc_nxt;
            Cout <= w_dcout;
            Ovf  <= w_dcmsb ^ w_dcout;
         end
      end
   end

endmodule

`default_nettype wire

// File: tb/tb_serial_addsub.sv
// ============================================================================
// Module      : tb_serial_addsub
// Description : Scoreboard bench for serial_addsub at DIGIT = 4, 1 and 16.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_serial_addsub;

   typedef struct packed {
      logic [15:0] sum;
      logic        cout;
      logic        ovf;
   } res_t;

   logic        clk;
   logic        rst_n;
   logic [15:0] A;
   logic [15:0] B;
   logic        Cin;
   logic        Sub;
   logic [2:0]  iv;
   logic [2:0]  ordy;
   logic [2:0]  irdy;
   logic [2:0]  ov;
   logic [15:0] sm [3];
   logic [2:0]  co;
   logic [2:0]  of;

   int   n_vec;
   int   n_err;
   res_t q[$];
   int   lat [3] = '{4, 16, 1};

   initial clk = 1'b0;
   always #5 clk = ~clk;

   serial_addsub #(.WIDTH(16), .DIGIT(4)) u_d4 (
      .clk(clk), .rst_n(rst_n), .in_valid(iv[0]), .in_ready(irdy[0]),
      .A(A), .B(B), .Cin(Cin), .Sub(Sub), .out_valid(ov[0]), .out_ready(ordy[0]),
      .Sum(sm[0]), .Cout(co[0]), .Ovf(of[0]));

   serial_addsub #(.WIDTH(16), .DIGIT(1)) u_d1 (
      .clk(clk), .rst_n(rst_n), .in_valid(iv[1]), .in_ready(irdy[1]),
      .A(A), .B(B), .Cin(Cin), .Sub(Sub), .out_valid(ov[1]), .out_ready(ordy[1]),
      .Sum(sm[1]), .Cout(co[1]), .Ovf(of[1]));

   serial_addsub #(.WIDTH(16), .DIGIT(16)) u_d16 (
      .clk(clk), .rst_n(rst_n), .in_valid(iv[2]), .in_ready(irdy[2]),
      .A(A), .B(B), .Cin(Cin), .Sub(Sub), .out_valid(ov[2]), .out_ready(ordy[2]),
      .Sum(sm[2]), .Cout(co[2]), .Ovf(of[2]));

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_vec++;
      if (got !== exp) begin
         n_err++;
         $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
      end
   endtask

   // Reference arithmetic written from the operand signs and magnitudes
   function automatic res_t model(input logic [15:0] a, input logic [15:0] b,
                                  input logic cin, input logic sub);
      res_t        r;
      logic [16:0] full;
      if (!sub) begin
         full   = {1'b0, a} + {1'b0, b} + 17'(cin);
         r.sum  = full[15:0];
         r.cout = full[16];
         r.ovf  = (a[15] == b[15]) && (r.sum[15] != a[15]);
      end else begin
         r.sum  = a - b - 16'(cin);
         r.cout = ({1'b0, a} >= ({1'b0, b} + 17'(cin)));
         r.ovf  = (a[15] != b[15]) && (r.sum[15] != a[15]);
      end
      return r;
   endfunction

   task automatic wait_valid(input int k, output int n);
      n = 0;
      while (!ov[k] && n < 40) begin
         @(posedge clk);
         #1;
         n++;
      end
   endtask

   task automatic collect(input int k, input string tag);
      res_t e;
      if (q.size() == 0) begin
         check({tag, "_queue_empty"}, 32'd0, 32'd1);
         return;
      end
      e = q.pop_front();
      check({tag, "_valid"}, 32'(ov[k]), 32'd1);
      check({tag, "_sum"},   32'(sm[k]), 32'(e.sum));
      check({tag, "_cout"},  32'(co[k]), 32'(e.cout));
      check({tag, "_ovf"},   32'(of[k]), 32'(e.ovf));
      @(negedge clk);
      ordy[k] = 1'b1;
      @(posedge clk);
      @(negedge clk);
      ordy[k] = 1'b0;
      check({tag, "_valid_drop"}, 32'(ov[k]), 32'd0);
   endtask

   task automatic do_op(input int k, input logic [15:0] a, input logic [15:0] b,
                        input logic cin, input logic sub, input string tag);
      int n;
      @(negedge clk);
      A = a; B = b; Cin = cin; Sub = sub;
      iv[k] = 1'b1;
      check({tag, "_in_ready"}, 32'(irdy[k]), 32'd1);
      @(posedge clk);
      q.push_back(model(a, b, cin, sub));
      @(negedge clk);
      iv[k] = 1'b0;
      wait_valid(k, n);
      check({tag, "_latency"}, 32'(n), 32'(lat[k]));
      collect(k, tag);
   endtask

   initial begin
      int   n;
      res_t e;
      n_vec = 0; n_err = 0;
      rst_n = 1'b0; iv = '0; ordy = '0;
      A = '0; B = '0; Cin = 1'b0; Sub = 1'b0;
      repeat (3) @(posedge clk);
      #1;
      for (int k = 0; k < 3; k++) begin
         check($sformatf("rst%0d_in_ready", k),  32'(irdy[k]), 32'd1);
         check($sformatf("rst%0d_out_valid", k), 32'(ov[k]),   32'd0);
         check($sformatf("rst%0d_sum", k),       32'(sm[k]),   32'd0);
         check($sformatf("rst%0d_cout", k),      32'(co[k]),   32'd0);
         check($sformatf("rst%0d_ovf", k),       32'(of[k]),   32'd0);
      end
      @(negedge clk);
      rst_n = 1'b1;

      do_op(0, 16'h1234, 16'h0FFF, 1'b0, 1'b0, "d4_add_basic");
      do_op(0, 16'hFFFF, 16'h0001, 1'b0, 1'b0, "d4_add_wrap");
      do_op(0, 16'h7FFF, 16'h0001, 1'b0, 1'b0, "d4_add_ovf");
      do_op(0, 16'h0005, 16'h0007, 1'b0, 1'b1, "d4_sub_neg");
      do_op(0, 16'h8000, 16'h0001, 1'b0, 1'b1, "d4_sub_ovf");
      do_op(0, 16'hA5A5, 16'h5A5A, 1'b1, 1'b0, "d4_add_cin");
      do_op(0, 16'h1000, 16'h0FFF, 1'b1, 1'b1, "d4_sub_bin");

      // Backpressure: result held while a new operand waits on the input side
      @(negedge clk);
      A = 16'h1111; B = 16'h2222; Cin = 1'b0; Sub = 1'b0; iv[0] = 1'b1;
      @(posedge clk);
      q.push_back(model(16'h1111, 16'h2222, 1'b0, 1'b0));
      @(negedge clk);
      A = 16'h0100; B = 16'h0200;
      wait_valid(0, n);
      check("bp_latency", 32'(n), 32'd4);
      e = q[0];
      for (int c = 0; c < 5; c++) begin
         @(negedge clk);
         check($sformatf("bp_hold_sum%0d", c),   32'(sm[0]),   32'(e.sum));
         check($sformatf("bp_hold_rdy%0d", c),   32'(irdy[0]), 32'd0);
         check($sformatf("bp_hold_valid%0d", c), 32'(ov[0]),   32'd1);
      end
      void'(q.pop_front());
      ordy[0] = 1'b1;
      @(posedge clk);
      @(negedge clk);
      ordy[0] = 1'b0;
      check("bp_second_waits", 32'(irdy[0]), 32'd1);
      check("bp_valid_drop",   32'(ov[0]),   32'd0);
      @(posedge clk);
      q.push_back(model(16'h0100, 16'h0200, 1'b0, 1'b0));
      @(negedge clk);
      iv[0] = 1'b0;
      wait_valid(0, n);
      check("bp2_latency", 32'(n), 32'd4);
      collect(0, "bp2");

      // Reset on the second RUN edge discards the operation
      @(negedge clk);
      A = 16'hBEEF; B = 16'h1234; Cin = 1'b0; Sub = 1'b0; iv[0] = 1'b1;
      @(posedge clk);
      @(negedge clk);
      iv[0] = 1'b0;
      @(posedge clk);
      @(negedge clk);
      rst_n = 1'b0;
      @(posedge clk);
      #1;
      check("mid_rst_valid", 32'(ov[0]),   32'd0);
      check("mid_rst_ready", 32'(irdy[0]), 32'd1);
      check("mid_rst_sum",   32'(sm[0]),   32'd0);
      @(negedge clk);
      rst_n = 1'b1;
      n = 0;
      repeat (6) begin
         @(negedge clk);
         if (ov[0]) n++;
      end
      check("mid_rst_no_result", 32'(n), 32'd0);
      do_op(0, 16'h0003, 16'h0004, 1'b0, 1'b0, "post_rst_add");

      do_op(1, 16'h1234, 16'h0FFF, 1'b0, 1'b0, "d1_add_basic");
      do_op(1, 16'h7FFF, 16'h0001, 1'b0, 1'b0, "d1_add_ovf");
      do_op(1, 16'h8000, 16'h0001, 1'b0, 1'b1, "d1_sub_ovf");
      do_op(2, 16'h1234, 16'h0FFF, 1'b0, 1'b0, "d16_add_basic");
      do_op(2, 16'h7FFF, 16'h0001, 1'b0, 1'b0, "d16_add_ovf");
      do_op(2, 16'h0005, 16'h0007, 1'b0, 1'b1, "d16_sub_neg");

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

endmodule

`default_nettype wire
